// File: rtl/bus_trace_uart.sv
// Z80 bus cycle tracer: synchronizes bus strobes, queues cycle records in a FIFO and
// streams each as a framed 8N1 UART message. Optional timestamps: BUS_TRACE_TIMESTAMP_EN.
module bus_trace_uart #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_DIV   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MREQ_n,
  input  logic              IORQ_n,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [7:0]        D,
  input  logic [3:0]        type_en,
  output logic              txd,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(BAUD_DIV);
`ifdef BUS_TRACE_TIMESTAMP_EN
  localparam int unsigned FRAME_LEN = 7;
  localparam int unsigned REC_W     = 42;
  localparam logic        TS_FLAG   = 1'b1;
`else
  localparam int unsigned FRAME_LEN = 5;
  localparam int unsigned REC_W     = 26;
  localparam logic        TS_FLAG   = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  logic [3:0]        strb_s1, strb_s2;
  logic [ADDR_W-1:0] a_s1, a_s2, addr_lat;
  logic [7:0]        d_s1, d_s2, data_lat;
  logic [3:0]        cyc_n, prev_n, rel, cand;
  logic              gen;
  logic [1:0]        gen_type;
  logic [15:0]       addr_ext;
  logic [REC_W-1:0]  rec_in, cur_rec;

  logic [REC_W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, empty, push, pop, drop;

  state_t            state, state_next;
  logic [TW-1:0]     tmr, tmr_next;
  logic              tmr_last, tmr_prelast, more_bytes;
  logic [2:0]        bit_idx, byte_idx;
  logic [7:0]        shreg, frame_byte;

  // Strobe order in the synchronizer: {WR_n, RD_n, IORQ_n, MREQ_n}
  always_ff @(posedge clk) begin
    if (rst) begin
      strb_s1 <= '1;
      strb_s2 <= '1;
      prev_n  <= '1;
      a_s1    <= '0;
      a_s2    <= '0;
      d_s1    <= '0;
      d_s2    <= '0;
    end else begin
      strb_s1 <= {WR_n, RD_n, IORQ_n, MREQ_n};
      strb_s2 <= strb_s1;
      prev_n  <= cyc_n;
      a_s1    <= A;
      a_s2    <= a_s1;
      d_s1    <= D;
      d_s2    <= d_s1;
    end
  end

  always_comb begin
    cyc_n[0] = strb_s2[0] | strb_s2[2];
    cyc_n[1] = strb_s2[0] | strb_s2[3];
    cyc_n[2] = strb_s2[1] | strb_s2[2];
    cyc_n[3] = strb_s2[1] | strb_s2[3];
  end

  assign rel  = ~prev_n & cyc_n;
  assign cand = rel & type_en;
  assign gen  = |cand;

  always_comb begin
    gen_type = 2'd3;
    if (cand[0])      gen_type = 2'd0;
    else if (cand[1]) gen_type = 2'd1;
    else if (cand[2]) gen_type = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lat <= '0;
      data_lat <= '0;
    end else if (~&cyc_n) begin
      addr_lat <= a_s2;
      data_lat <= d_s2;
    end
  end

  always_comb begin
    addr_ext                = '0;
    addr_ext[ADDR_W-1:0]    = addr_lat;
  end

`ifdef BUS_TRACE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + 16'd1;
  end

  assign rec_in = {ts, gen_type, addr_ext, data_lat};
`else
  assign rec_in = {gen_type, addr_ext, data_lat};
`endif

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push  = gen && (!full || pop);
  assign drop  = gen && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign tmr_last    = (tmr == TW'(BAUD_DIV - 1));
  assign tmr_prelast = (tmr == TW'(BAUD_DIV - 2));
  assign tmr_next    = tmr_last ? '0 : tmr + TW'(1);
  assign more_bytes  = (byte_idx != 3'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Between bytes STOP hands over one cycle early; the LOAD cycle supplies the final
  // stop-bit clock so consecutive bytes stay exactly 10*BAUD_DIV apart.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:  state_next = START;
      START: if (tmr_last) state_next = DATA;
      DATA:  if (tmr_last && bit_idx == 3'd7) state_next = STOP;
      STOP: begin
        if (more_bytes && tmr_prelast)       state_next = LOAD;
        else if (!more_bytes && tmr_last)    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_byte = '0;
    case (byte_idx)
      3'd0: frame_byte = 8'h5A;
      3'd1: frame_byte = {TS_FLAG, 5'b0, cur_rec[25:24]};
      3'd2: frame_byte = cur_rec[23:16];
      3'd3: frame_byte = cur_rec[15:8];
      3'd4: frame_byte = cur_rec[7:0];
`ifdef BUS_TRACE_TIMESTAMP_EN
      3'd5: frame_byte = cur_rec[41:34];
      3'd6: frame_byte = cur_rec[33:26];
`endif
      default: frame_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '1;
      cur_rec  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmr      <= '0;
          byte_idx <= '0;
          if (pop) cur_rec <= mem[rd_ptr];
        end
        LOAD: begin
          tmr     <= '0;
          bit_idx <= '0;
          shreg   <= frame_byte;
        end
        START: tmr <= tmr_next;
        DATA: begin
          tmr <= tmr_next;
          if (tmr_last) begin
            shreg   <= {1'b1, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          tmr <= tmr_next;
          if (more_bytes && tmr_prelast) byte_idx <= byte_idx + 3'd1;
        end
        default: tmr <= '0;
      endcase
    end
  end

  always_comb begin
    txd = 1'b1;
    if (state == START)     txd = 1'b0;
    else if (state == DATA) txd = shreg[0];
  end

  assign busy = !empty || (state != IDLE);

endmodule
